pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage Kaiserlake pipeline (S0 decode, S1 readreg, S2 execute, S3 memwrt, S4 regwrt).
- Watches register usage of the instruction leaving S1 and the destinations of older instructions in S3/S4/writeback.
- Drives: S1 update enable, per-stage bubble resets rst_p[4:1], forwarding selects for the three S2 operand muxes, PC hold/redirect.
- Owns the load-use stall FSM, branch flush, halt, and a stall-cycle performance counter.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- used_RmRnRd_1out  in  3  operand-use flags of S1-out instruction; bit2 Rm, bit1 Rn, bit0 Rd
- num_Rm_1out, num_Rn_1out, num_Rd_1out  in  3 each  register numbers of the S1-out instruction
- write_2out, writenum_2out  in  1/3  destination of the S2-out instruction (now in S3)
- write_3out, writenum_3out  in  1/3  destination of the S3-out instruction (now in S4)
- write_out, writenum_out  in  1/3  writeback destination (regfile write this cycle)
- loads_2out  in  1  S2-out instruction is a load
- branch_taken_in  in  1  taken branch resolved in S3 this cycle
- halt_in  in  1  HALT instruction resolved in S3 this cycle
- update_1in  out  1  S1 capture enable (0 = hold)
- rst_p  out  4  [4:1] bubble/flush reset per stage register
- fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel  out  2 each  0 regfile, 1 result_2out_3in, 2 result_3out_4in, 3 writeback_data_out
- pc_hold  out  1  freeze PC/IR fetch
- pc_redirect  out  1  load PC from branch target
- halted  out  1  pipeline halted
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: state RUN, update_1in=1, rst_p=4'b0000, fwd_*_sel=0, pc_hold=0, pc_redirect=0, halted=0, stall_cycles=0, load_in_s4=0.
- load_in_s4 register: load_in_s4 <= loads_2out && write_2out every cycle. S3/S4 never stall, so this tracks the load now in S4.
- Match rules:
  - m2(x) = used(x) && write_2out && writenum_2out==num_x
  - m3(x) = used(x) && write_3out && writenum_3out==num_x
  - mw(x) = used(x) && write_out && writenum_out==num_x
- Forward select per operand (combinational), youngest wins:
  - m2 && !loads_2out -> 1
  - else m3 && !load_in_s4 -> 2
  - else mw -> 3
  - else 0
- Load-use detection (combinational):
  - hz2 = any m2(x) with loads_2out
  - hz3 = any m3(x) with load_in_s4 and no non-load m2 on that operand
- FSM states RUN, LSTALL, HALT:
  - RUN, hz2: update_1in=0, rst_p[2]=1, pc_hold=1. Go to LSTALL; the next cycle is a second bubble, since the load's memory data is only valid at writeback.
  - RUN, hz3 only: one-cycle stall with the same outputs; stay in RUN. Next cycle the load is at writeback and forwarding via sel 3 resolves it.
  - LSTALL: update_1in=0, rst_p[2]=1, pc_hold=1 unconditionally; return to RUN.
  - HALT: update_1in=0, pc_hold=1, rst_p[2]=1 every cycle, halted=1. Older instructions drain through S3/S4. Exit only on rst.
- Branch: branch_taken_in in RUN or LSTALL gives, for one cycle, rst_p[1]=1, rst_p[2]=1, pc_redirect=1, update_1in=1, pc_hold=0.
  - Next state is RUN; any pending stall is cancelled because the consumer was flushed.
  - Branch beats load stall in the same cycle.
- Halt: halt_in gives rst_p[1]=1, rst_p[2]=1, enter HALT next cycle. halt_in beats branch_taken_in.
- rst_p[3], rst_p[4] stay 0 except while rst=1. The top level ORs rst in separately.
- stall_cycles increments on every cycle with pc_hold=1 in RUN/LSTALL; saturates at all-ones; not incremented in HALT.
- Reset mid-stall or in HALT: next cycle state RUN, all outputs at reset values.
- Register r0 has no special meaning: matches on 0 forward normally.

Decomposition:
- Shared package pipeline_pkg:
  - hazard_state_t enum (RUN, LSTALL, HALT)
  - fwd_sel_t constants FWD_REG=0, FWD_S3=1, FWD_S4=2, FWD_WB=3
  - USE_RM/USE_RN/USE_RD bit indices
- One sub-module, pipeline_fwd_select: instantiated three times. It computes one operand's select and load-hazard bits from (used, num, producer fields, loads_2out, load_in_s4).

Test Plan:
- ALU R1 in S3, consumer uses Rm=1 -> fwd_Rm_sel=1, update_1in=1, no stall.
- Load R2 in S3 (loads_2out=1), consumer Rn=2 -> two cycles update_1in=0, rst_p=4'b0010, pc_hold=1. Third cycle fwd_Rn_sel=3, stall_cycles=2.
- Load R3 now in S4, consumer Rd=3 with no S3 match -> exactly one stall cycle, then fwd_Rd_sel=3.
- Load-use stall first cycle plus branch_taken_in=1 -> rst_p=4'b0011, pc_redirect=1, next state RUN, no second bubble.
- halt_in=1 -> next cycles halted=1, update_1in=0, pc_hold=1. rst=1 -> all outputs return to reset values the following cycle.
- Drive 65540 hz3 stalls -> stall_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the Kaiserlake pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        HALT   = 2'd2
    } hazard_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'd0;
    localparam fwd_sel_t FWD_S3  = 2'd1;
    localparam fwd_sel_t FWD_S4  = 2'd2;
    localparam fwd_sel_t FWD_WB  = 2'd3;

    localparam int USE_RM = 2;
    localparam int USE_RN = 1;
    localparam int USE_RD = 0;

endpackage

// File: rtl/pipeline_fwd_select.sv
// Per-operand forwarding select and load-use hazard detection.
module pipeline_fwd_select
    import pipeline_pkg::*;
(
    input  logic       used,
    input  logic [2:0] num,
    input  logic       write_2out,
    input  logic [2:0] writenum_2out,
    input  logic       write_3out,
    input  logic [2:0] writenum_3out,
    input  logic       write_out,
    input  logic [2:0] writenum_out,
    input  logic       loads_2out,
    input  logic       load_in_s4,
    output fwd_sel_t   sel,
    output logic       hz2,
    output logic       hz3
);

    logic m2;
    logic m3;
    logic mw;

    assign m2 = used && write_2out && (writenum_2out == num);
    assign m3 = used && write_3out && (writenum_3out == num);
    assign mw = used && write_out  && (writenum_out  == num);

    // Youngest producer wins; loads cannot forward until writeback.
    always_comb begin
        sel = FWD_REG;
        if (m2 && !loads_2out) begin
            sel = FWD_S3;
        end else if (m3 && !load_in_s4) begin
            sel = FWD_S4;
        end else if (mw) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
    end

    assign hz2 = m2 && loads_2out;
    assign hz3 = m3 && load_in_s4 && !(m2 && !loads_2out);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stalls, branch flush, halt.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       used_RmRnRd_1out,
    input  logic [2:0]       num_Rm_1out,
    input  logic [2:0]       num_Rn_1out,
    input  logic [2:0]       num_Rd_1out,
    input  logic             write_2out,
    input  logic [2:0]       writenum_2out,
    input  logic             write_3out,
    input  logic [2:0]       writenum_3out,
    input  logic             write_out,
    input  logic [2:0]       writenum_out,
    input  logic             loads_2out,
    input  logic             branch_taken_in,
    input  logic             halt_in,
    output logic             update_1in,
    output logic [4:1]       rst_p,
    output logic [1:0]       fwd_Rm_sel,
    output logic [1:0]       fwd_Rn_sel,
    output logic [1:0]       fwd_Rd_sel,
    output logic             pc_hold,
    output logic             pc_redirect,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    hazard_state_t    state_q, state_d;
    logic             load_in_s4_q, load_in_s4_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]       hz2_v, hz3_v;
    logic             hz2, hz3;

    pipeline_fwd_select u_fwd_rm (
        .used(used_RmRnRd_1out[USE_RM]), .num(num_Rm_1out),
        .write_2out(write_2out), .writenum_2out(writenum_2out),
        .write_3out(write_3out), .writenum_3out(writenum_3out),
        .write_out(write_out), .writenum_out(writenum_out),
        .loads_2out(loads_2out), .load_in_s4(load_in_s4_q),
        .sel(fwd_Rm_sel), .hz2(hz2_v[USE_RM]), .hz3(hz3_v[USE_RM])
    );

    pipeline_fwd_select u_fwd_rn (
        .used(used_RmRnRd_1out[USE_RN]), .num(num_Rn_1out),
        .write_2out(write_2out), .writenum_2out(writenum_2out),
        .write_3out(write_3out), .writenum_3out(writenum_3out),
        .write_out(write_out), .writenum_out(writenum_out),
        .loads_2out(loads_2out), .load_in_s4(load_in_s4_q),
        .sel(fwd_Rn_sel), .hz2(hz2_v[USE_RN]), .hz3(hz3_v[USE_RN])
    );

    pipeline_fwd_select u_fwd_rd (
        .used(used_RmRnRd_1out[USE_RD]), .num(num_Rd_1out),
        .write_2out(write_2out), .writenum_2out(writenum_2out),
        .write_3out(write_3out), .writenum_3out(writenum_3out),
        .write_out(write_out), .writenum_out(writenum_out),
        .loads_2out(loads_2out), .load_in_s4(load_in_s4_q),
        .sel(fwd_Rd_sel), .hz2(hz2_v[USE_RD]), .hz3(hz3_v[USE_RD])
    );

    assign hz2 = |hz2_v;
    assign hz3 = |hz3_v;

    // Next-state and stage control; halt beats branch, branch beats a load stall.
    always_comb begin
        state_d     = state_q;
        update_1in  = 1'b1;
        rst_p       = 4'b0000;
        pc_hold     = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            RUN, LSTALL: begin
                if (halt_in) begin
                    rst_p   = 4'b0011;
                    state_d = HALT;
                end else if (branch_taken_in) begin
                    rst_p       = 4'b0011;
                    pc_redirect = 1'b1;
                    state_d     = RUN;
                end else if ((state_q == LSTALL) || hz2 || hz3) begin
                    update_1in = 1'b0;
                    rst_p      = 4'b0010;
                    pc_hold    = 1'b1;
                    state_d    = ((state_q == RUN) && hz2) ? LSTALL : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                update_1in = 1'b0;
                rst_p      = 4'b0010;
                pc_hold    = 1'b1;
                state_d    = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating stall counter, frozen while halted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // S3/S4 never stall, so the S2-out load flag is the load now in S4 next cycle.
    assign load_in_s4_d = loads_2out && write_2out;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            load_in_s4_q <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            load_in_s4_q <= load_in_s4_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign halted       = (state_q == HALT);
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  used_RmRnRd_1out, num_Rm_1out, num_Rn_1out, num_Rd_1out;
    logic        write_2out, write_3out, write_out;
    logic [2:0]  writenum_2out, writenum_3out, writenum_out;
    logic        loads_2out, branch_taken_in, halt_in;
    logic        update_1in, pc_hold, pc_redirect, halted;
    logic [4:1]  rst_p;
    logic [1:0]  fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel;
    logic [15:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .used_RmRnRd_1out(used_RmRnRd_1out),
        .num_Rm_1out(num_Rm_1out), .num_Rn_1out(num_Rn_1out), .num_Rd_1out(num_Rd_1out),
        .write_2out(write_2out), .writenum_2out(writenum_2out),
        .write_3out(write_3out), .writenum_3out(writenum_3out),
        .write_out(write_out), .writenum_out(writenum_out),
        .loads_2out(loads_2out), .branch_taken_in(branch_taken_in), .halt_in(halt_in),
        .update_1in(update_1in), .rst_p(rst_p),
        .fwd_Rm_sel(fwd_Rm_sel), .fwd_Rn_sel(fwd_Rn_sel), .fwd_Rd_sel(fwd_Rd_sel),
        .pc_hold(pc_hold), .pc_redirect(pc_redirect), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and return all stimulus to an idle pipeline.
    task automatic next_cycle();
        @(negedge clk);
        used_RmRnRd_1out = 3'b000;
        num_Rm_1out = 3'd0; num_Rn_1out = 3'd0; num_Rd_1out = 3'd0;
        write_2out = 1'b0; writenum_2out = 3'd0;
        write_3out = 1'b0; writenum_3out = 3'd0;
        write_out  = 1'b0; writenum_out  = 3'd0;
        loads_2out = 1'b0; branch_taken_in = 1'b0; halt_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_update", update_1in, 1'b1);
        chk("rst_rst_p", rst_p, 4'b0000);
        chk("rst_sel", {fwd_Rm_sel, fwd_Rn_sel, fwd_Rd_sel}, 6'd0);
        chk("rst_pc", {pc_hold, pc_redirect, halted}, 3'b000);
        chk("rst_stall", stall_cycles, 16'd0);

        // ALU R1 in S3 feeding Rm
        next_cycle();
        write_2out = 1'b1; writenum_2out = 3'd1;
        used_RmRnRd_1out = 3'b100; num_Rm_1out = 3'd1;
        #1;
        chk("alu_s3_sel", fwd_Rm_sel, 2'd1);
        chk("alu_s3_upd", {update_1in, pc_hold}, 2'b10);

        // All three producers match; youngest wins
        next_cycle();
        write_2out = 1'b1; writenum_2out = 3'd1;
        write_3out = 1'b1; writenum_3out = 3'd1;
        write_out  = 1'b1; writenum_out  = 3'd1;
        used_RmRnRd_1out = 3'b100; num_Rm_1out = 3'd1;
        #1;
        chk("prio_sel", fwd_Rm_sel, 2'd1);

        // r0 forwards from S4; unused Rm ignored; Rn from writeback
        next_cycle();
        write_3out = 1'b1; writenum_3out = 3'd0;
        write_out  = 1'b1; writenum_out  = 3'd7;
        used_RmRnRd_1out = 3'b011; num_Rm_1out = 3'd7; num_Rn_1out = 3'd7; num_Rd_1out = 3'd0;
        #1;
        chk("r0_sel", fwd_Rd_sel, 2'd2);
        chk("wb_sel", fwd_Rn_sel, 2'd3);
        chk("unused_sel", fwd_Rm_sel, 2'd0);

        // Load R2 in S3, consumer Rn=2: two bubbles then writeback forward
        next_cycle();
        loads_2out = 1'b1; write_2out = 1'b1; writenum_2out = 3'd2;
        used_RmRnRd_1out = 3'b010; num_Rn_1out = 3'd2;
        #1;
        chk("lu1_ctrl", {update_1in, rst_p, pc_hold}, {1'b0, 4'b0010, 1'b1});
        next_cycle();
        write_3out = 1'b1; writenum_3out = 3'd2;
        used_RmRnRd_1out = 3'b010; num_Rn_1out = 3'd2;
        #1;
        chk("lu2_ctrl", {update_1in, rst_p, pc_hold}, {1'b0, 4'b0010, 1'b1});
        next_cycle();
        write_out = 1'b1; writenum_out = 3'd2;
        used_RmRnRd_1out = 3'b010; num_Rn_1out = 3'd2;
        #1;
        chk("lu3_sel", fwd_Rn_sel, 2'd3);
        chk("lu3_ctrl", {update_1in, rst_p, pc_hold}, {1'b1, 4'b0000, 1'b0});
        chk("lu3_cnt", stall_cycles, 16'd2);

        // Load R3 reaches S4 while consumer Rd=3 arrives: single bubble
        next_cycle();
        loads_2out = 1'b1; write_2out = 1'b1; writenum_2out = 3'd3;
        #1;
        chk("h3_pre", update_1in, 1'b1);
        next_cycle();
        write_3out = 1'b1; writenum_3out = 3'd3;
        used_RmRnRd_1out = 3'b001; num_Rd_1out = 3'd3;
        #1;
        chk("h3_ctrl", {update_1in, rst_p, pc_hold}, {1'b0, 4'b0010, 1'b1});
        chk("h3_sel", fwd_Rd_sel, 2'd0);
        next_cycle();
        write_out = 1'b1; writenum_out = 3'd3;
        used_RmRnRd_1out = 3'b001; num_Rd_1out = 3'd3;
        #1;
        chk("h3_fwd", {update_1in, fwd_Rd_sel}, {1'b1, 2'd3});
        chk("h3_cnt", stall_cycles, 16'd3);

        // Branch in the same cycle as a load-use hazard
        next_cycle();
        loads_2out = 1'b1; write_2out = 1'b1; writenum_2out = 3'd2;
        used_RmRnRd_1out = 3'b010; num_Rn_1out = 3'd2;
        branch_taken_in = 1'b1;
        #1;
        chk("br_ctrl", {update_1in, rst_p, pc_hold, pc_redirect}, {1'b1, 4'b0011, 1'b0, 1'b1});
        next_cycle();
        #1;
        chk("br_next", {update_1in, rst_p, pc_hold, pc_redirect}, {1'b1, 4'b0000, 1'b0, 1'b0});
        chk("br_cnt", stall_cycles, 16'd3);

        // Halt beats branch, then freezes the front end
        next_cycle();
        halt_in = 1'b1; branch_taken_in = 1'b1;
        #1;
        chk("halt_in", {rst_p, pc_redirect, halted}, {4'b0011, 1'b0, 1'b0});
        next_cycle();
        #1;
        chk("halt_1", {halted, update_1in, pc_hold, rst_p}, {1'b1, 1'b0, 1'b1, 4'b0010});
        next_cycle();
        branch_taken_in = 1'b1;
        #1;
        chk("halt_2", {halted, update_1in, pc_hold, pc_redirect}, {1'b1, 1'b0, 1'b1, 1'b0});
        chk("halt_cnt", stall_cycles, 16'd3);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("unhalt", {halted, update_1in, pc_hold, rst_p}, {1'b0, 1'b1, 1'b0, 4'b0000});
        chk("unhalt_cnt", stall_cycles, 16'd0);

        // Back-to-back S4-load hazards: cycle 0 primes load_in_s4, then every cycle stalls
        for (int i = 0; i <= 65540; i++) begin
            next_cycle();
            loads_2out = 1'b1; write_2out = 1'b1; writenum_2out = 3'd5;
            write_3out = 1'b1; writenum_3out = 3'd4;
            used_RmRnRd_1out = 3'b100; num_Rm_1out = 3'd4;
            #1;
            if (i == 65535) chk("sat_near", stall_cycles, 16'hFFFE);
            if (i == 65536) chk("sat_hit", stall_cycles, 16'hFFFF);
        end
        chk("sat_hold", stall_cycles, 16'hFFFF);
        chk("sat_stall", pc_hold, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
